// File: rtl/amm_traffic_driver.sv
// Avalon-MM traffic master: turns test commands into write bursts carrying a seeded
// counting pattern, or into read burst requests, and tracks read beats still owed.
module amm_traffic_driver #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 128,
    parameter int DATA_B_W     = DATA_W / 8,
    parameter int AMM_BURST_W  = 11,
    parameter int MAX_RD_OUTST = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   test_start_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_op_i,
    input  logic [ADDR_W-1:0]      cmd_addr_i,
    input  logic [AMM_BURST_W-1:0] cmd_burstcount_i,
    input  logic [DATA_B_W-1:0]    cmd_byteenable_i,
    input  logic [31:0]            cmd_seed_i,
    output logic [ADDR_W-1:0]      address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [AMM_BURST_W-1:0] burstcount_o,
    output logic [DATA_B_W-1:0]    byteenable_o,
    output logic [DATA_W-1:0]      writedata_o,
    input  logic                   waitrequest_i,
    input  logic                   readdatavalid_i,
    output logic                   busy_o,
    output logic                   rdv_err_o,
    output logic [1:0]             dbg_state_o
);

    // Handshakes: a command transfers on an edge where cmd_valid_i && cmd_ready_o;
    // an Avalon beat/request transfers on an edge where (write_o || read_o) && !waitrequest_i.

    localparam int LANES = DATA_W / 32;
    localparam int PTR_W = $clog2(MAX_RD_OUTST);
    localparam int OUT_W = $clog2(MAX_RD_OUTST) + 1;
    localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_RD_OUTST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t                 state;
    logic [31:0]            seed_r;
    logic [AMM_BURST_W-1:0] beat_idx;
    logic [AMM_BURST_W-1:0] beat_nxt;
    logic [AMM_BURST_W-1:0] fifo_mem [MAX_RD_OUTST];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [OUT_W-1:0]       outst;
    logic [AMM_BURST_W-1:0] head_cnt;
    logic                   push;
    logic                   rdv_ok;
    logic                   pop;

    assign beat_nxt    = beat_idx + 1'b1;
    assign cmd_ready_o = (state == S_IDLE) && (outst < MAX_CNT);
    assign busy_o      = (state != S_IDLE) || (outst != '0);
    assign dbg_state_o = state;

    // A read request leaving the bus is a burst we now owe beats for.
    assign push   = (state == S_RD) && !waitrequest_i;
    assign rdv_ok = readdatavalid_i && (outst != '0);
    assign pop    = rdv_ok && ((head_cnt + 1'b1) == fifo_mem[rd_ptr]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            read_o       <= 1'b0;
            write_o      <= 1'b0;
            address_o    <= '0;
            burstcount_o <= '0;
            byteenable_o <= '0;
            writedata_o  <= '0;
            seed_r       <= '0;
            beat_idx     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o && (cmd_burstcount_i != '0)) begin
                        address_o    <= cmd_addr_i;
                        burstcount_o <= cmd_burstcount_i;
                        beat_idx     <= '0;
                        seed_r       <= cmd_seed_i;
                        if (cmd_op_i) begin
                            state        <= S_RD;
                            read_o       <= 1'b1;
                            byteenable_o <= '1;
                        end else begin
                            state        <= S_WR;
                            write_o      <= 1'b1;
                            byteenable_o <= cmd_byteenable_i;
                            writedata_o  <= {LANES{cmd_seed_i}};
                        end
                    end
                end
                S_WR: begin
                    if (!waitrequest_i) begin
                        if (beat_idx == burstcount_o - 1'b1) begin
                            write_o <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            beat_idx    <= beat_nxt;
                            writedata_o <= {LANES{seed_r + 32'(beat_nxt)}};
                        end
                    end
                end
                S_RD: begin
                    if (!waitrequest_i) begin
                        read_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < MAX_RD_OUTST; i++) fifo_mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            outst     <= '0;
            head_cnt  <= '0;
            rdv_err_o <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= burstcount_o;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (rdv_ok) begin
                if (pop) begin
                    head_cnt <= '0;
                    rd_ptr   <= rd_ptr + 1'b1;
                end else begin
                    head_cnt <= head_cnt + 1'b1;
                end
            end
            if (push && !pop) outst <= outst + 1'b1;
            else if (pop && !push) outst <= outst - 1'b1;
            // A stray beat outranks a simultaneous clear so the error is never lost.
            if (readdatavalid_i && (outst == '0)) rdv_err_o <= 1'b1;
            else if (test_start_i) rdv_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_amm_traffic_driver.sv
// Bench for amm_traffic_driver: directed scenarios plus randomized commands, checked
// against a transaction-level model and a queue of expected bus transfers.
module tb_amm_traffic_driver;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int DB_W   = 16;
    localparam int BC_W   = 11;
    localparam int MAXO   = 4;

    typedef struct packed {
        logic              is_rd;
        logic [ADDR_W-1:0] addr;
        logic [BC_W-1:0]   bc;
        logic [DB_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              test_start_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_op_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [BC_W-1:0]   cmd_burstcount_i;
    logic [DB_W-1:0]   cmd_byteenable_i;
    logic [31:0]       cmd_seed_i;
    logic [ADDR_W-1:0] address_o;
    logic              read_o;
    logic              write_o;
    logic [BC_W-1:0]   burstcount_o;
    logic [DB_W-1:0]   byteenable_o;
    logic [DATA_W-1:0] writedata_o;
    logic              waitrequest_i;
    logic              readdatavalid_i;
    logic              busy_o;
    logic              rdv_err_o;
    logic [1:0]        dbg_state_o;

    exp_t exp_q[$];
    int   m_outs[$];
    bit   m_in_prog;
    bit   m_is_rd;
    int   m_left;
    int   m_bc;
    bit   m_err;
    bit   e_ready;
    bit   e_busy;
    exp_t h;
    int   wr_hi_cnt;
    int   n_cmp;
    int   n_fail;
    bit   rand_en;

    always #5 clk_i = ~clk_i;

    amm_traffic_driver dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .test_start_i     (test_start_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_op_i         (cmd_op_i),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_burstcount_i (cmd_burstcount_i),
        .cmd_byteenable_i (cmd_byteenable_i),
        .cmd_seed_i       (cmd_seed_i),
        .address_o        (address_o),
        .read_o           (read_o),
        .write_o          (write_o),
        .burstcount_o     (burstcount_o),
        .byteenable_o     (byteenable_o),
        .writedata_o      (writedata_o),
        .waitrequest_i    (waitrequest_i),
        .readdatavalid_i  (readdatavalid_i),
        .busy_o           (busy_o),
        .rdv_err_o        (rdv_err_o),
        .dbg_state_o      (dbg_state_o)
    );

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model state, then advance the model by this cycle's inputs.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            m_in_prog = 1'b0;
            m_err     = 1'b0;
            m_outs.delete();
            exp_q.delete();
        end else begin
            e_ready = !m_in_prog && (m_outs.size() < MAXO);
            e_busy  = m_in_prog || (m_outs.size() != 0);
            chk("cmd_ready", cmd_ready_o, e_ready);
            chk("busy", busy_o, e_busy);
            chk("write_o", write_o, m_in_prog && !m_is_rd);
            chk("read_o", read_o, m_in_prog && m_is_rd);
            chk("rdv_err", rdv_err_o, m_err);
            if (write_o || read_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL bus_unexpected: got transfer expected none (t=%0t)", $time);
                end else begin
                    h = exp_q[0];
                    chk("xfer_is_rd", read_o, h.is_rd);
                    chk("address", address_o, h.addr);
                    chk("burstcount", burstcount_o, h.bc);
                    chk("byteenable", byteenable_o, h.be);
                    if (!h.is_rd) chk("writedata", writedata_o, h.data);
                    if (!waitrequest_i) void'(exp_q.pop_front());
                end
                if (write_o) wr_hi_cnt++;
            end
            if (readdatavalid_i && m_outs.size() == 0) m_err = 1'b1;
            else if (test_start_i) m_err = 1'b0;
            if (readdatavalid_i && m_outs.size() != 0) begin
                m_outs[0] = m_outs[0] - 1;
                if (m_outs[0] == 0) void'(m_outs.pop_front());
            end
            if (m_in_prog && !waitrequest_i) begin
                if (m_is_rd) begin
                    m_outs.push_back(m_bc);
                    m_in_prog = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) m_in_prog = 1'b0;
                end
            end
            if (cmd_valid_i && e_ready && cmd_burstcount_i != 0) begin
                m_in_prog = 1'b1;
                m_is_rd   = cmd_op_i;
                m_left    = int'(cmd_burstcount_i);
                m_bc      = int'(cmd_burstcount_i);
            end
        end
    end

    // Background randomized bus responder, only while rand_en is set.
    always @(posedge clk_i) begin
        #1;
        if (rand_en) begin
            waitrequest_i   = ($urandom_range(0, 3) == 0);
            readdatavalid_i = (m_outs.size() != 0) && ($urandom_range(0, 1) == 1);
            test_start_i    = ($urandom_range(0, 15) == 0);
        end
    end

    task automatic send_cmd(input bit op, input logic [31:0] addr, input logic [BC_W-1:0] bc,
                            input logic [DB_W-1:0] be, input logic [31:0] seed);
        exp_t e;
        bit   ok = 1'b0;
        cmd_op_i         = op;
        cmd_addr_i       = addr;
        cmd_burstcount_i = bc;
        cmd_byteenable_i = be;
        cmd_seed_i       = seed;
        cmd_valid_i      = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk_i);
            if (cmd_ready_o) begin
                ok = 1'b1;
                if (op && bc != 0) begin
                    e = '{is_rd: 1'b1, addr: addr, bc: bc, be: '1, data: '0};
                    exp_q.push_back(e);
                end else begin
                    for (int i = 0; i < int'(bc); i++) begin
                        e = '{is_rd: 1'b0, addr: addr, bc: bc, be: be,
                              data: {4{seed + 32'(i)}}};
                        exp_q.push_back(e);
                    end
                end
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_accept: got no acceptance within 300 cycles expected acceptance");
        end
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(posedge clk_i);
            #1;
            done = !m_in_prog && (m_outs.size() == 0) && (exp_q.size() == 0);
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: got still busy after 500 cycles expected idle");
        end
    endtask

    task automatic drain_reads();
        for (int t = 0; t < 200; t++) begin
            if (!m_in_prog && m_outs.size() == 0) break;
            readdatavalid_i = (m_outs.size() != 0);
            @(posedge clk_i);
            #1;
        end
        readdatavalid_i = 1'b0;
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          c0;
        logic [9:0]  pat;
        logic [31:0] seed;
        n_cmp = 0; n_fail = 0; wr_hi_cnt = 0; rand_en = 1'b0;
        rst_n_i = 1'b0; test_start_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = 1'b0;
        cmd_addr_i = '0; cmd_burstcount_i = '0; cmd_byteenable_i = '0; cmd_seed_i = '0;
        waitrequest_i = 1'b0; readdatavalid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_write", write_o, 1'b0);
        chk("rst_read", read_o, 1'b0);
        chk("rst_ready", cmd_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_address", address_o, '0);
        chk("rst_writedata", writedata_o, '0);
        rst_n_i = 1'b1;

        // Plain write burst.
        c0 = wr_hi_cnt;
        send_cmd(1'b0, 32'h100, 11'd4, 16'hFFFF, 32'h10);
        wait_idle();
        chk("wr_cycles_plain", wr_hi_cnt - c0, 4);

        // Same write with stalls on beats 1 and 2.
        c0 = wr_hi_cnt;
        pat = 10'b0011101110;
        send_cmd(1'b0, 32'h100, 11'd4, 16'hFFFF, 32'h10);
        for (int i = 0; i < 10; i++) begin
            waitrequest_i = pat[i];
            @(posedge clk_i);
            #1;
        end
        waitrequest_i = 1'b0;
        wait_idle();
        chk("wr_cycles_stalled", wr_hi_cnt - c0, 10);

        // Five reads against a four-deep outstanding limit.
        for (int k = 0; k < 4; k++) send_cmd(1'b1, 32'h200 + 32'(k * 64), 11'd2, '0, '0);
        fork
            send_cmd(1'b1, 32'h400, 11'd2, '0, '0);
            begin
                repeat (4) @(posedge clk_i);
                #1;
                chk("rd_full_ready", cmd_ready_o, 1'b0);
                readdatavalid_i = 1'b1;
                repeat (2) @(posedge clk_i);
                #1;
                readdatavalid_i = 1'b0;
            end
        join
        drain_reads();

        // New read request lands in the same cycle as the last beat of the head burst.
        send_cmd(1'b1, 32'h800, 11'd3, '0, '0);
        send_cmd(1'b1, 32'h900, 11'd1, '0, '0);
        @(posedge clk_i);
        #1;
        readdatavalid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        readdatavalid_i = 1'b0;
        fork
            send_cmd(1'b1, 32'hA00, 11'd2, '0, '0);
            begin
                @(posedge clk_i);
                #1;
                readdatavalid_i = 1'b1;
                @(posedge clk_i);
                #1;
                readdatavalid_i = 1'b0;
            end
        join
        chk("pp_ready", cmd_ready_o, 1'b1);
        chk("pp_busy", busy_o, 1'b1);
        drain_reads();
        chk("pp_busy_end", busy_o, 1'b0);

        // Stray readdatavalid and the sticky error flag.
        readdatavalid_i = 1'b1;
        @(posedge clk_i);
        #1;
        readdatavalid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("err_sticky", rdv_err_o, 1'b1);
        test_start_i = 1'b1;
        @(posedge clk_i);
        #1;
        test_start_i = 1'b0;
        chk("err_cleared", rdv_err_o, 1'b0);
        test_start_i = 1'b1;
        readdatavalid_i = 1'b1;
        @(posedge clk_i);
        #1;
        test_start_i = 1'b0;
        readdatavalid_i = 1'b0;
        chk("err_wins", rdv_err_o, 1'b1);
        test_start_i = 1'b1;
        @(posedge clk_i);
        #1;
        test_start_i = 1'b0;

        // Reset in the middle of an 8-beat write, then a fresh burst.
        send_cmd(1'b0, 32'h300, 11'd8, 16'hFFFF, 32'h55);
        repeat (2) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("rst_mid_write", write_o, 1'b0);
        chk("rst_mid_ready", cmd_ready_o, 1'b1);
        chk("rst_mid_busy", busy_o, 1'b0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        send_cmd(1'b0, 32'h300, 11'd3, 16'h0F0F, 32'h77);
        wait_idle();

        // Randomized command mix with random waitrequest/readdatavalid.
        rand_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            seed = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
            send_cmd(1'($urandom_range(0, 1)), $urandom, 11'($urandom_range(0, 6)),
                     16'($urandom), seed);
        end
        wait_idle();
        rand_en = 1'b0;
        @(posedge clk_i);
        #1;
        waitrequest_i = 1'b0;
        readdatavalid_i = 1'b0;
        test_start_i = 1'b0;
        repeat (2) @(posedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
